uart_rx_poller: RTL and testbench

- Register-bus master on the uart_16750 host interface, sitting downstream of the UART config FSM; takes bus ownership once configuration is done.
- Polls LSR; when Data Ready is set and local space exists, reads RBR and pushes the byte into an internal FIFO presented as a valid/ready byte stream.
- Latches LSR line-error bits (OE/PE/FE/BI) as sticky flags for status/LED logic.

---
 rtl/uart_rx_poller.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_poller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_poller.sv
// Register-bus master for a uart_16750: polls LSR, drains RBR into a local byte FIFO
// exposed as a valid/ready stream, and keeps sticky line-error flags from LSR[4:1].
module uart_rx_poller #(
    parameter int FIFO_DEPTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int POLL_GAP     = 16
) (
    input  logic                        clk_33M,
    input  logic                        rstn,
    input  logic                        enable,
    output logic                        uart_cs,
    output logic                        uart_rd,
    output logic                        uart_wr,
    output logic [2:0]                  uart_addr,
    input  logic [7:0]                  uart_dout,
    output logic [7:0]                  m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [3:0]                  err_flags,
    input  logic                        err_clr
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (POLL_GAP > READ_LATENCY) ? POLL_GAP : READ_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [2:0] ADDR_LSR = 3'b101;
    localparam logic [2:0] ADDR_RBR = 3'b000;

    typedef enum logic [3:0] {
        IDLE, LSR_SETUP, LSR_RD, LSR_WAIT, EVAL,
        RBR_SETUP, RBR_RD, RBR_WAIT, PUSH, GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_cap;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic [7:0]       r_head;
    logic [3:0]       r_err;

    logic             w_in_wait;
    logic             w_wait_done;
    logic             w_gap_done;
    logic             w_space;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_ptr_inc;

    assign w_in_wait    = (r_state == LSR_WAIT) || (r_state == RBR_WAIT);
    assign w_wait_done  = (r_cnt == CNT_W'(READ_LATENCY - 1));
    assign w_gap_done   = (r_cnt == CNT_W'(POLL_GAP));
    assign w_space      = (r_level != (PTR_W+1)'(FIFO_DEPTH));
    assign w_push       = (r_state == PUSH);
    assign w_pop        = (r_level != '0) && m_ready;
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    always_ff @(posedge clk_33M or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        uart_cs      = 1'b0;
        uart_rd      = 1'b0;
        uart_addr    = ADDR_RBR;
        case (r_state)
            IDLE: if (enable) w_state_next = LSR_SETUP;
            LSR_SETUP: begin
                uart_cs      = 1'b1;
                uart_addr    = ADDR_LSR;
                w_state_next = LSR_RD;
            end
            LSR_RD: begin
                uart_cs      = 1'b1;
                uart_rd      = 1'b1;
                uart_addr    = ADDR_LSR;
                w_state_next = LSR_WAIT;
            end
            LSR_WAIT: begin
                uart_cs   = 1'b1;
                uart_addr = ADDR_LSR;
                if (w_wait_done) w_state_next = EVAL;
            end
            // FIFO space is reserved here; only pops can happen before the PUSH.
            EVAL: begin
                if (!enable)                  w_state_next = IDLE;
                else if (r_cap[0] && w_space) w_state_next = RBR_SETUP;
                else                          w_state_next = GAP;
            end
            RBR_SETUP: begin
                uart_cs      = 1'b1;
                w_state_next = RBR_RD;
            end
            RBR_RD: begin
                uart_cs      = 1'b1;
                uart_rd      = 1'b1;
                w_state_next = RBR_WAIT;
            end
            RBR_WAIT: begin
                uart_cs = 1'b1;
                if (w_wait_done) w_state_next = PUSH;
            end
            PUSH: w_state_next = enable ? LSR_SETUP : IDLE;
            GAP:  if (w_gap_done) w_state_next = enable ? LSR_SETUP : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign uart_wr = 1'b0;

    // Shared counter: read-latency wait and the inter-poll gap (POLL_GAP+1 cycles in GAP).
    always_ff @(posedge clk_33M or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_cap <= '0;
        end else begin
            if (w_in_wait)            r_cnt <= w_wait_done ? '0 : r_cnt + 1'b1;
            else if (r_state == GAP)  r_cnt <= w_gap_done ? '0 : r_cnt + 1'b1;
            else                      r_cnt <= '0;
            if (w_in_wait && w_wait_done) r_cap <= uart_dout;
        end
    end

    always_ff @(posedge clk_33M) begin
        if (w_push) r_mem[r_wr_ptr] <= r_cap;
    end

    // Head is a registered copy so m_data comes straight from a flop.
    always_ff @(posedge clk_33M or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_push && ((r_level == '0) || ((r_level == (PTR_W+1)'(1)) && w_pop)))
                r_head <= r_cap;
            else if (w_pop && (r_level > (PTR_W+1)'(1)))
                r_head <= r_mem[w_rd_ptr_inc];
        end
    end

    always_ff @(posedge clk_33M or negedge rstn) begin
        if (!rstn)
            r_err <= '0;
        else if (err_clr || (r_state == EVAL))
            r_err <= (err_clr ? 4'b0000 : r_err) | ((r_state == EVAL) ? r_cap[4:1] : 4'b0000);
    end

    assign m_data     = r_head;
    assign m_valid    = (r_level != '0);
    assign fifo_level = r_level;
    assign err_flags  = r_err;

endmodule

// File: tb/tb_uart_rx_poller.sv
// Bench for uart_rx_poller: behavioural UART register model plus a byte scoreboard
// checked on every accepted stream beat.
module tb_uart_rx_poller;
    localparam int FIFO_DEPTH   = 8;
    localparam int READ_LATENCY = 1;
    localparam int POLL_GAP     = 16;

    logic       clk_33M = 1'b0;
    logic       rstn    = 1'b0;
    logic       enable  = 1'b0;
    logic       m_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic       uart_cs, uart_rd, uart_wr;
    logic [2:0] uart_addr;
    logic [7:0] uart_dout = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic [3:0] fifo_level;
    logic [3:0] err_flags;

    uart_rx_poller #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .READ_LATENCY(READ_LATENCY),
        .POLL_GAP    (POLL_GAP)
    ) dut (
        .clk_33M   (clk_33M),
        .rstn      (rstn),
        .enable    (enable),
        .uart_cs   (uart_cs),
        .uart_rd   (uart_rd),
        .uart_wr   (uart_wr),
        .uart_addr (uart_addr),
        .uart_dout (uart_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .fifo_level(fifo_level),
        .err_flags (err_flags),
        .err_clr   (err_clr)
    );

    always #15 clk_33M = ~clk_33M;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         n_lsr = 0;
    int         n_rbr = 0;
    int         n_valid_cyc = 0;
    logic       prev_rd = 1'b0;
    logic [7:0] uart_q[$];
    logic [7:0] sb[$];
    logic [3:0] inj_bits = 4'b0000;
    int         inj_seq = 0;
    int         inj_used = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // UART register model with one-cycle read latency; injected error bits apply to one LSR read.
    always @(posedge clk_33M) begin
        logic [3:0] e;
        if (uart_cs && uart_rd) begin
            if (uart_addr == 3'b101) begin
                e = (inj_seq != inj_used) ? inj_bits : 4'b0000;
                uart_dout <= {3'b000, e, (uart_q.size() != 0)};
                inj_used  <= inj_seq;
            end else if (uart_q.size() != 0) begin
                uart_dout <= uart_q.pop_front();
            end else begin
                uart_dout <= 8'hEE;
            end
        end
    end

    always @(negedge clk_33M) begin
        #1;
        cyc++;
        if (uart_rd) begin
            chk("rd_with_cs", 32'(uart_cs), 1);
            chk("rd_single_cycle", 32'(prev_rd), 0);
            if (uart_addr == 3'b101)      n_lsr++;
            else if (uart_addr == 3'b000) n_rbr++;
            else                          chk("rd_addr", 32'(uart_addr), 5);
        end
        prev_rd = uart_rd;
        if (m_valid) n_valid_cyc++;
        if (m_valid && m_ready) begin
            $display("rx byte 0x%02h at cycle %0d", m_data, cyc);
            if (sb.size() == 0) chk("sb_unexpected_byte", 32'(m_data), 32'h100);
            else                chk("sb_byte", 32'(m_data), 32'(sb.pop_front()));
        end
    end

    task automatic wait_rd(input logic [2:0] a, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_33M); #2;
            if (uart_rd && (uart_addr == a)) ok = 1'b1;
        end
        chk("wait_rd", 32'(ok), 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk_33M); #2;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic send(input logic [7:0] b);
        uart_q.push_back(b);
        sb.push_back(b);
    endtask

    initial begin
        int t0, nr0, nv0, nl0;

        repeat (3) @(negedge clk_33M);
        #2;
        chk("rst_cs", 32'(uart_cs), 0);
        chk("rst_rd", 32'(uart_rd), 0);
        chk("rst_wr", 32'(uart_wr), 0);
        chk("rst_addr", 32'(uart_addr), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_err", 32'(err_flags), 0);
        chk("rst_data", 32'(m_data), 0);

        // Idle polling cadence.
        @(negedge clk_33M);
        rstn   = 1'b1;
        enable = 1'b1;
        wait_rd(3'b101, 50);
        for (int k = 0; k < 3; k++) begin
            t0 = cyc;
            @(negedge clk_33M); #2;
            chk("lsr_wait_cs", 32'(uart_cs), 1);
            chk("lsr_wait_rd", 32'(uart_rd), 0);
            chk("lsr_wait_addr", 32'(uart_addr), 5);
            @(negedge clk_33M); #2;
            chk("lsr_eval_cs", 32'(uart_cs), 0);
            wait_rd(3'b101, 50);
            chk("poll_period", cyc - t0, 21);
            chk("idle_valid", 32'(m_valid), 0);
        end

        // Single byte with consumer ready.
        @(negedge clk_33M);
        m_ready = 1'b1;
        nr0 = n_rbr;
        nv0 = n_valid_cyc;
        send(8'h20);
        wait_drain(200);
        repeat (5) @(negedge clk_33M);
        #2;
        chk("single_rbr_reads", n_rbr - nr0, 1);
        chk("single_valid_cycles", n_valid_cyc - nv0, 1);
        chk("single_level", 32'(fifo_level), 0);

        // Burst larger than the FIFO with consumer stalled.
        @(negedge clk_33M);
        m_ready = 1'b0;
        nr0 = n_rbr;
        for (int b = 0; b < 10; b++) send(8'(b));
        repeat (300) @(negedge clk_33M);
        #2;
        chk("full_level", 32'(fifo_level), 8);
        chk("full_rbr_reads", n_rbr - nr0, 8);
        chk("full_valid", 32'(m_valid), 1);
        chk("full_head", 32'(m_data), 0);
        nl0 = n_lsr;
        repeat (100) @(negedge clk_33M);
        #2;
        chk("full_keeps_polling", 32'((n_lsr - nl0) >= 4), 1);
        chk("full_no_rbr", n_rbr - nr0, 8);
        @(negedge clk_33M);
        m_ready = 1'b1;
        wait_drain(600);
        repeat (10) @(negedge clk_33M);
        #2;
        chk("burst_rbr_reads", n_rbr - nr0, 10);
        chk("burst_level", 32'(fifo_level), 0);

        // Sticky FE, then clear coinciding with a new PE report.
        wait_rd(3'b101, 50);
        @(negedge clk_33M);
        inj_bits = 4'b0100;
        inj_seq++;
        send(8'h55);
        wait_drain(200);
        repeat (2) @(negedge clk_33M);
        #2;
        chk("fe_flag", 32'(err_flags), 32'h4);
        repeat (40) @(negedge clk_33M);
        #2;
        chk("fe_sticky", 32'(err_flags), 32'h4);
        wait_rd(3'b101, 50);
        @(negedge clk_33M);
        inj_bits = 4'b0010;
        inj_seq++;
        wait_rd(3'b101, 50);
        @(negedge clk_33M);
        @(negedge clk_33M);
        err_clr = 1'b1;
        @(negedge clk_33M);
        err_clr = 1'b0;
        #2;
        chk("clr_vs_pe", 32'(err_flags), 32'h2);

        // Enable dropped while an RBR read is in flight.
        @(negedge clk_33M);
        send(8'h77);
        wait_rd(3'b000, 100);
        @(negedge clk_33M);
        enable = 1'b0;
        #2;
        chk("drop_wait_cs", 32'(uart_cs), 1);
        @(negedge clk_33M); #2;
        @(negedge clk_33M); #2;
        chk("drop_idle_cs", 32'(uart_cs), 0);
        chk("drop_pushed", 32'(m_valid), 1);
        chk("drop_data", 32'(m_data), 32'h77);
        nr0 = n_lsr + n_rbr;
        repeat (60) @(negedge clk_33M);
        #2;
        chk("drop_no_reads", n_lsr + n_rbr - nr0, 0);
        chk("drop_delivered", sb.size(), 0);

        // Asynchronous reset with three bytes held and an RBR read in flight.
        @(negedge clk_33M);
        enable  = 1'b1;
        m_ready = 1'b0;
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        for (int i = 0; i < 300 && fifo_level != 4'd3; i++) begin
            @(negedge clk_33M); #2;
        end
        chk("pre_rst_level", 32'(fifo_level), 3);
        @(negedge clk_33M);
        send(8'hA4);
        wait_rd(3'b000, 100);
        @(negedge clk_33M);
        #5;
        rstn = 1'b0;
        #1;
        chk("arst_cs", 32'(uart_cs), 0);
        chk("arst_rd", 32'(uart_rd), 0);
        chk("arst_valid", 32'(m_valid), 0);
        chk("arst_level", 32'(fifo_level), 0);
        chk("arst_err", 32'(err_flags), 0);
        sb.delete();
        uart_q.delete();
        repeat (2) @(negedge clk_33M);
        rstn    = 1'b1;
        m_ready = 1'b1;
        send(8'h5A);
        wait_drain(200);
        repeat (3) @(negedge clk_33M);
        #2;
        chk("recover_level", 32'(fifo_level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
